video_timing_rx: RTL and testbench

Input-side video timing receiver: locks to the incoming VGA stream (I_HSYNC/I_VSYNC/I_DE), produces registered pixel data with column/row coordinates, start-of-frame and end-of-line strobes, and validates line and frame geometry against the configured 640x480 timing. It is the decoding counterpart to video_timing_gen and sits between the top-level pixel inputs and the buffered colorspace/Sobel path, in the I_PCLK domain.

---
 rtl/edge_detection_pkg.sv | 18 +
 rtl/sync_edge_detect.sv | 33 +++
 rtl/video_timing_rx.sv | 213 +++++++++++++++++++++
 tb/tb_video_timing_rx.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_detection_pkg.sv
// rtl/edge_detection_pkg.sv - VGA 640x480 timing constants, rx lock states and coordinate widths
package edge_detection_pkg;

    localparam int HACT   = 640;
    localparam int HTOTAL = 800;
    localparam int VACT   = 480;

    localparam int COL_W  = $clog2(HACT);
    localparam int ROW_W  = $clog2(VACT);
    localparam int CNT_W  = 12;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } rx_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - two-stage capture of one timing signal, normalised to active-high, with rise/fall pulses
module sync_edge_detect #(
    parameter logic POL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic cur_o,
    output logic prev_o,
    output logic rise_o,
    output logic fall_o
);

    logic s1_q;
    logic s2_q;

    // Stage 1 holds the normalised level, stage 2 the previous stage-1 value
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= (raw_i == POL);
            s2_q <= s1_q;
        end
    end

    assign cur_o  = s1_q;
    assign prev_o = s2_q;
    assign rise_o = s1_q & ~s2_q;
    assign fall_o = ~s1_q & s2_q;

endmodule

// File: rtl/video_timing_rx.sv
// rtl/video_timing_rx.sv - VGA timing receiver with coordinates, strobes and geometry lock; optional error counter: VIDEO_TIMING_RX_ERR_CNT_EN
module video_timing_rx
    import edge_detection_pkg::*;
#(
    parameter int   VGA_HACT    = HACT,
    parameter int   VGA_HTOTAL  = HTOTAL,
    parameter int   VGA_VACT    = VACT,
    parameter logic SYNC_POL    = 1'b0,
    parameter int   LOCK_FRAMES = 2
) (
    input  logic                        I_PCLK,
    input  logic                        I_RST,
    input  logic [23:0]                 I_PIX_DATA,
    input  logic                        I_HSYNC,
    input  logic                        I_VSYNC,
    input  logic                        I_DE,
    output logic [23:0]                 O_PIX_DATA,
    output logic                        O_DE,
    output logic [$clog2(VGA_HACT)-1:0] O_COL,
    output logic [$clog2(VGA_VACT)-1:0] O_ROW,
    output logic                        O_SOF,
    output logic                        O_EOL,
    output logic                        O_LOCKED,
    output logic                        O_ERR,
    output logic [15:0]                 O_ERR_CNT
);

    localparam int CW = $clog2(VGA_HACT);
    localparam int RW = $clog2(VGA_VACT);

    localparam logic [CNT_W-1:0] HACT_C   = CNT_W'(VGA_HACT);
    localparam logic [CNT_W-1:0] HTOTAL_C = CNT_W'(VGA_HTOTAL);
    localparam logic [CNT_W-1:0] VACT_C   = CNT_W'(VGA_VACT);
    localparam logic [CW-1:0]    LAST_COL = CW'(VGA_HACT - 1);
    localparam logic [3:0]       LOCK_C   = 4'(LOCK_FRAMES);

    logic hs_cur, hs_prev, hs_rise, hs_fall;
    logic vs_cur, vs_prev, vs_rise, vs_fall;
    logic de_cur, de_prev, de_rise, de_fall;

    sync_edge_detect #(.POL(SYNC_POL)) u_hs (
        .clk_i (I_PCLK), .rst_i (I_RST), .raw_i (I_HSYNC),
        .cur_o (hs_cur), .prev_o (hs_prev), .rise_o (hs_rise), .fall_o (hs_fall)
    );

    sync_edge_detect #(.POL(SYNC_POL)) u_vs (
        .clk_i (I_PCLK), .rst_i (I_RST), .raw_i (I_VSYNC),
        .cur_o (vs_cur), .prev_o (vs_prev), .rise_o (vs_rise), .fall_o (vs_fall)
    );

    sync_edge_detect #(.POL(1'b1)) u_de (
        .clk_i (I_PCLK), .rst_i (I_RST), .raw_i (I_DE),
        .cur_o (de_cur), .prev_o (de_prev), .rise_o (de_rise), .fall_o (de_fall)
    );

    // Only the rising edges of the syncs carry timing information here
    logic unused_edges;
    assign unused_edges = ^{hs_cur, hs_prev, hs_fall, vs_cur, vs_prev, vs_fall};

    logic [23:0]      pix_s1_q, pix_s2_q;
    logic [CW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_q, row_d;
    logic [CNT_W-1:0] run_q, run_d;
    logic [CNT_W-1:0] line_q, line_d, line_total;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic             hs_seen_q;
    logic             sof_q, sof_d;
    logic             eol_q, eol_d;
    logic             err_q, err_now;
    logic             frame_err_q, frame_err_d;
    logic [3:0]       good_q, good_d;
    rx_state_e        state_q, state_d;

    logic chk_en, err_run, err_line, err_frame;

    // Pixel pipeline, two stages so it lines up with the delayed DE
    always_ff @(posedge I_PCLK or posedge I_RST) begin
        if (I_RST) begin
            pix_s1_q <= '0;
            pix_s2_q <= '0;
        end else begin
            pix_s1_q <= I_PIX_DATA;
            pix_s2_q <= pix_s1_q;
        end
    end

    // Coordinate, run-length, line-count and line-period counters
    always_comb begin
        col_d = col_q;
        if (de_rise)                   col_d = '0;
        else if (de_cur && col_q != '1) col_d = col_q + CW'(1);

        row_d = row_q;
        if (vs_rise)                    row_d = '0;
        else if (de_fall && row_q != '1) row_d = row_q + RW'(1);

        run_d = run_q;
        if (de_rise)                    run_d = CNT_W'(1);
        else if (de_cur && run_q != '1) run_d = run_q + CNT_W'(1);

        // A line ending on the same cycle as vsync belongs to the frame being closed
        line_total = (de_fall && line_q != '1) ? line_q + CNT_W'(1) : line_q;
        line_d     = vs_rise ? '0 : line_total;

        hcnt_d = hcnt_q;
        if (hs_rise)            hcnt_d = '0;
        else if (hcnt_q != '1)  hcnt_d = hcnt_q + CNT_W'(1);

        chk_en    = (state_q != ST_SEARCH);
        err_run   = de_fall && (run_q != HACT_C);
        err_line  = hs_rise && hs_seen_q && ((hcnt_q + CNT_W'(1)) != HTOTAL_C);
        err_frame = vs_rise && (line_total != VACT_C);
        err_now   = chk_en && (err_run || err_line || err_frame);

        sof_d = chk_en && de_rise && (row_d == '0);
        eol_d = de_cur && (col_d == LAST_COL);
    end

    // Lock state machine: clean frames accumulate, any violation restarts the count
    always_comb begin
        state_d     = state_q;
        good_d      = good_q;
        frame_err_d = vs_rise ? 1'b0 : (frame_err_q | err_now);
        case (state_q)
            ST_SEARCH: begin
                if (vs_rise) begin
                    state_d = ST_MEASURE;
                    good_d  = '0;
                end
            end
            ST_MEASURE: begin
                if (vs_rise) begin
                    if (!frame_err_q && !err_now) begin
                        good_d = good_q + 4'd1;
                        if (good_q + 4'd1 == LOCK_C) state_d = ST_LOCKED;
                    end else begin
                        good_d = '0;
                    end
                end else if (err_now) begin
                    good_d = '0;
                end
            end
            ST_LOCKED: begin
                if (err_now) begin
                    state_d = ST_MEASURE;
                    good_d  = '0;
                end
            end
            default: begin
                state_d = ST_SEARCH;
                good_d  = '0;
            end
        endcase
    end

    // Counter, strobe and state registers
    always_ff @(posedge I_PCLK or posedge I_RST) begin
        if (I_RST) begin
            col_q       <= '0;
            row_q       <= '0;
            run_q       <= '0;
            line_q      <= '0;
            hcnt_q      <= '0;
            hs_seen_q   <= 1'b0;
            sof_q       <= 1'b0;
            eol_q       <= 1'b0;
            err_q       <= 1'b0;
            frame_err_q <= 1'b0;
            good_q      <= '0;
            state_q     <= ST_SEARCH;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            run_q       <= run_d;
            line_q      <= line_d;
            hcnt_q      <= hcnt_d;
            hs_seen_q   <= hs_seen_q | hs_rise;
            sof_q       <= sof_d;
            eol_q       <= eol_d;
            err_q       <= err_now;
            frame_err_q <= frame_err_d;
            good_q      <= good_d;
            state_q     <= state_d;
        end
    end

`ifdef VIDEO_TIMING_RX_ERR_CNT_EN
    logic [15:0] err_cnt_q;

    // Saturating tally of error pulses, cleared only by reset
    always_ff @(posedge I_PCLK or posedge I_RST) begin
        if (I_RST) begin
            err_cnt_q <= '0;
        end else if (err_q && err_cnt_q != 16'hFFFF) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign O_ERR_CNT = err_cnt_q;
`else
    assign O_ERR_CNT = 16'd0;
`endif

    assign O_PIX_DATA = pix_s2_q;
    assign O_DE       = de_prev;
    assign O_COL      = col_q;
    assign O_ROW      = row_q;
    assign O_SOF      = sof_q;
    assign O_EOL      = eol_q;
    assign O_ERR      = err_q;
    assign O_LOCKED   = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_video_timing_rx.sv
// tb/tb_video_timing_rx.sv - randomized bench for video_timing_rx against an event-timestamp reference model
module tb_video_timing_rx;

    localparam int HACT  = 20;
    localparam int HTOT  = 28;
    localparam int HSW   = 3;
    localparam int HBP   = 2;
    localparam int VACT  = 6;
    localparam int VSW   = 1;
    localparam int VBP   = 1;
    localparam int VTOT  = 9;
    localparam int LOCKN = 2;
    localparam logic SPOL = 1'b0;
    localparam int CW = $clog2(HACT);
    localparam int RW = $clog2(VACT);
    localparam int COLMAX = (1 << CW) - 1;
    localparam int ROWMAX = (1 << RW) - 1;
    localparam int MAXC = 16384;

    logic          I_PCLK = 1'b0;
    logic          I_RST = 1'b1;
    logic [23:0]   I_PIX_DATA = '0;
    logic          I_HSYNC = ~SPOL;
    logic          I_VSYNC = ~SPOL;
    logic          I_DE = 1'b0;
    logic [23:0]   O_PIX_DATA;
    logic          O_DE;
    logic [CW-1:0] O_COL;
    logic [RW-1:0] O_ROW;
    logic          O_SOF, O_EOL, O_LOCKED, O_ERR;
    logic [15:0]   O_ERR_CNT;

    video_timing_rx #(
        .VGA_HACT(HACT), .VGA_HTOTAL(HTOT), .VGA_VACT(VACT),
        .SYNC_POL(SPOL), .LOCK_FRAMES(LOCKN)
    ) dut (
        .I_PCLK(I_PCLK), .I_RST(I_RST), .I_PIX_DATA(I_PIX_DATA),
        .I_HSYNC(I_HSYNC), .I_VSYNC(I_VSYNC), .I_DE(I_DE),
        .O_PIX_DATA(O_PIX_DATA), .O_DE(O_DE), .O_COL(O_COL), .O_ROW(O_ROW),
        .O_SOF(O_SOF), .O_EOL(O_EOL), .O_LOCKED(O_LOCKED), .O_ERR(O_ERR),
        .O_ERR_CNT(O_ERR_CNT)
    );

    always #5 I_PCLK = ~I_PCLK;

    int n_cmp = 0;
    int n_bad = 0;

    // input history since the last reset, sync levels stored active-high
    bit          de_h  [MAXC];
    bit          hs_h  [MAXC];
    bit          vs_h  [MAXC];
    logic [23:0] pix_h [MAXC];
    int          n_idx;

    // reference model: timestamps of last edges plus lock bookkeeping
    int last_de_rise, last_hs_rise, falls_vs;
    int m_state, m_good, m_cnt;
    bit m_dirty, m_prev_err;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s idx=%0d: got 0x%0h, want 0x%0h", tag, n_idx, act, exp);
        end
    endtask

    function automatic bit de_at(input int i);
        return (i < 0) ? 1'b0 : de_h[i];
    endfunction
    function automatic bit hs_at(input int i);
        return (i < 0) ? 1'b0 : hs_h[i];
    endfunction
    function automatic bit vs_at(input int i);
        return (i < 0) ? 1'b0 : vs_h[i];
    endfunction

    task automatic model_reset();
        n_idx = 0;
        last_de_rise = -1;
        last_hs_rise = -1;
        falls_vs = 0;
        m_state = 0;
        m_good = 0;
        m_cnt = 0;
        m_dirty = 1'b0;
        m_prev_err = 1'b0;
    endtask

    // outputs after a clock edge describe input sample j (two cycles of latency)
    task automatic check_outputs(input int j);
        bit de, derise, defall, hsr, vsr, chk_en, err, sof, eol;
        int col, row, lines;
        de     = de_at(j);
        derise = de && !de_at(j - 1);
        defall = !de && de_at(j - 1);
        hsr    = hs_at(j) && !hs_at(j - 1);
        vsr    = vs_at(j) && !vs_at(j - 1);
        chk_en = (m_state != 0);
        lines  = falls_vs + (defall ? 1 : 0);
        err = chk_en && ((defall && (j - last_de_rise) != HACT) ||
                         (hsr && last_hs_rise >= 0 && (j - last_hs_rise) != HTOT) ||
                         (vsr && lines != VACT));
        if (derise) last_de_rise = j;
        if (hsr)    last_hs_rise = j;
        falls_vs = vsr ? 0 : lines;
        col = (j - last_de_rise > COLMAX) ? COLMAX : j - last_de_rise;
        row = (falls_vs > ROWMAX) ? ROWMAX : falls_vs;
        sof = chk_en && derise && row == 0;
        eol = de && col == HACT - 1;
        if (vsr) begin
            if (m_state == 0) begin
                m_state = 1; m_good = 0;
            end else if (m_state == 1) begin
                if (!m_dirty && !err) begin
                    m_good++;
                    if (m_good == LOCKN) m_state = 2;
                end else m_good = 0;
            end else if (err) begin
                m_state = 1; m_good = 0;
            end
        end else if (err) begin
            m_state = 1; m_good = 0;
        end
        m_dirty = vsr ? 1'b0 : (m_dirty | err);
        if (m_prev_err && m_cnt < 65535) m_cnt++;
        m_prev_err = err;

        chk("de", 32'(O_DE), 32'(de));
        chk("pix", 32'(O_PIX_DATA), 32'(pix_h[j]));
        if (de) begin
            chk("col", 32'(O_COL), 32'(col));
            chk("row", 32'(O_ROW), 32'(row));
        end
        chk("sof", 32'(O_SOF), 32'(sof));
        chk("eol", 32'(O_EOL), 32'(eol));
        chk("err", 32'(O_ERR), 32'(err));
        chk("locked", 32'(O_LOCKED), 32'(m_state == 2));
`ifdef VIDEO_TIMING_RX_ERR_CNT_EN
        chk("err_cnt", 32'(O_ERR_CNT), 32'(m_cnt));
`else
        chk("err_cnt", 32'(O_ERR_CNT), 32'd0);
`endif
    endtask

    task automatic cyc(input bit de, input bit hs, input bit vs);
        logic [23:0] px;
        px = 24'($urandom);
        I_DE = de;
        I_HSYNC = hs ? SPOL : ~SPOL;
        I_VSYNC = vs ? SPOL : ~SPOL;
        I_PIX_DATA = px;
        if (n_idx >= MAXC) begin
            $display("FAIL history_overflow idx=%0d: got %0d, want < %0d", n_idx, n_idx, MAXC);
            $fatal(1);
        end
        de_h[n_idx] = de;
        hs_h[n_idx] = hs;
        vs_h[n_idx] = vs;
        pix_h[n_idx] = px;
        @(posedge I_PCLK);
        #1;
        if (n_idx == 0) chk("de_after_reset", 32'(O_DE), 32'd0);
        else check_outputs(n_idx - 1);
        n_idx++;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pix"}, 32'(O_PIX_DATA), 32'd0);
        chk({tag, "_de"}, 32'(O_DE), 32'd0);
        chk({tag, "_col"}, 32'(O_COL), 32'd0);
        chk({tag, "_row"}, 32'(O_ROW), 32'd0);
        chk({tag, "_sof"}, 32'(O_SOF), 32'd0);
        chk({tag, "_eol"}, 32'(O_EOL), 32'd0);
        chk({tag, "_locked"}, 32'(O_LOCKED), 32'd0);
        chk({tag, "_err"}, 32'(O_ERR), 32'd0);
        chk({tag, "_errcnt"}, 32'(O_ERR_CNT), 32'd0);
    endtask

    task automatic do_reset();
        I_RST = 1'b1;
        #2;
        chk_all_zero("rst_async");
        repeat (3) @(posedge I_PCLK);
        #1;
        chk_all_zero("rst_held");
        I_RST = 1'b0;
        model_reset();
    endtask

    task automatic send_line(input bit vs, input bit act, input int de_len, input int total, input int rst_pos);
        for (int c = 0; c < total; c++) begin
            if (c == rst_pos) do_reset();
            cyc(act && c >= HSW + HBP && c < HSW + HBP + de_len, c < HSW, vs);
        end
    endtask

    // one frame: vsync line, back porch, n_act active lines, blanking to VTOT
    task automatic send_frame(input int pert_line, input int de_delta, input int extra,
                              input int n_act, input int rst_line, input int rst_pos);
        for (int l = 0; l < VTOT; l++) begin
            send_line(l < VSW,
                      l >= VSW + VBP && (l - VSW - VBP) < n_act,
                      (l == pert_line) ? HACT + de_delta : HACT,
                      (l == pert_line) ? HTOT + extra : HTOT,
                      (l == rst_line) ? rst_pos : -1);
        end
    endtask

    task automatic clean_frame();
        send_frame(-1, 0, 0, VACT, -1, -1);
    endtask

    initial begin
        model_reset();
        do_reset();

        repeat (3) clean_frame();
        chk("lock_after_3_frames", 32'(O_LOCKED), 32'd1);

        send_frame(4, -1, 0, VACT, -1, -1);
        chk("unlock_short_de", 32'(O_LOCKED), 32'd0);
`ifdef VIDEO_TIMING_RX_ERR_CNT_EN
        chk("err_cnt_one", 32'(O_ERR_CNT), 32'd1);
`else
        chk("err_cnt_off", 32'(O_ERR_CNT), 32'd0);
`endif
        repeat (2) clean_frame();
        chk("not_yet_relocked", 32'(O_LOCKED), 32'd0);
        clean_frame();
        chk("relocked", 32'(O_LOCKED), 32'd1);

        send_frame(5, 0, 1, VACT, -1, -1);
        chk("unlock_long_line", 32'(O_LOCKED), 32'd0);
        repeat (3) clean_frame();
        chk("relock_after_long", 32'(O_LOCKED), 32'd1);

        send_frame(-1, 0, 0, VACT - 1, -1, -1);
        clean_frame();
        chk("unlock_short_frame", 32'(O_LOCKED), 32'd0);

        repeat (12) begin
            int kind, pl;
            kind = int'($urandom_range(0, 4));
            pl = int'($urandom_range(VSW + VBP, VSW + VBP + VACT - 1));
            case (kind)
                1:       send_frame(pl, -1, 0, VACT, -1, -1);
                2:       send_frame(pl, 1, 0, VACT, -1, -1);
                3:       send_frame(pl, 0, 1, VACT, -1, -1);
                4:       send_frame(-1, 0, 0, VACT - 1, -1, -1);
                default: clean_frame();
            endcase
        end

        send_frame(-1, 0, 0, VACT, 4, 10);
        chk("search_after_reset", 32'(O_LOCKED), 32'd0);
        repeat (2) clean_frame();
        chk("measure_after_reset", 32'(O_LOCKED), 32'd0);
        clean_frame();
        chk("lock_after_reset", 32'(O_LOCKED), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
